// File: rtl/morse_receiver_if.sv
// Signal bundle between the tick/bit source and the Morse letter decoder.
// The source side is the master; the decoder is the slave.
interface morse_receiver_if;
    logic       tick;
    logic       bit_in;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    modport master (
        output tick,
        output bit_in,
        input  letter,
        input  valid,
        input  error,
        input  busy
    );

    modport slave (
        input  tick,
        input  bit_in,
        output letter,
        output valid,
        output error,
        output busy
    );
endinterface

// File: rtl/morse_receiver.sv
// Decodes a ticked serial Morse stream into the letters S..Z.
// A dot is one high bit and a dash three; letters end after three low bits.
module morse_receiver (
    input  logic              clock,
    input  logic              reset,
    morse_receiver_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARK    = 2'd1,
        SPACE   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam int MAX_ELEMS = 4;

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] mark_run_reg;
    logic [2:0] mark_run_next;
    logic [1:0] space_run_reg;
    logic [1:0] space_run_next;
    logic [2:0] count_reg;
    logic [2:0] count_next;
    logic [3:0] elem_reg;
    logic [3:0] elem_next;
    logic [2:0] letter_reg;
    logic [2:0] letter_next;
    logic       valid_reg;
    logic       valid_next;
    logic       error_reg;
    logic       error_next;

    logic       store_en;
    logic       store_dash;
    logic       clear_en;
    logic       match;
    logic [2:0] match_code;

    // Elements are stored first-received in bit 0; dot = 0, dash = 1.
    // Unused slots are always zero, so a full-width compare is exact.
    always_comb begin
        match      = 1'b1;
        match_code = 3'b000;
        case ({count_reg, elem_reg})
            {3'd3, 4'b0000}: match_code = 3'b000; // S ...
            {3'd1, 4'b0001}: match_code = 3'b001; // T -
            {3'd3, 4'b0100}: match_code = 3'b010; // U ..-
            {3'd4, 4'b1000}: match_code = 3'b011; // V ...-
            {3'd3, 4'b0110}: match_code = 3'b100; // W .--
            {3'd4, 4'b1001}: match_code = 3'b101; // X -..-
            {3'd4, 4'b1101}: match_code = 3'b110; // Y -.--
            {3'd4, 4'b0011}: match_code = 3'b111; // Z --..
            default:         match      = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        mark_run_next  = mark_run_reg;
        space_run_next = space_run_reg;
        count_next     = count_reg;
        letter_next    = letter_reg;
        valid_next     = 1'b0;
        error_next     = 1'b0;
        store_en       = 1'b0;
        store_dash     = 1'b0;
        clear_en       = 1'b0;

        if (bus.tick) begin
            case (state_reg)
                IDLE: begin
                    if (bus.bit_in) begin
                        state_next    = MARK;
                        mark_run_next = 3'd1;
                    end
                end

                MARK: begin
                    if (bus.bit_in) begin
                        if (mark_run_reg != 3'd7) begin
                            mark_run_next = mark_run_reg + 3'd1;
                        end
                    end else if ((mark_run_reg == 3'd1 || mark_run_reg == 3'd3) &&
                                 (count_reg < 3'(MAX_ELEMS))) begin
                        store_en       = 1'b1;
                        store_dash     = (mark_run_reg == 3'd3);
                        count_next     = count_reg + 3'd1;
                        state_next     = SPACE;
                        space_run_next = 2'd1;
                    end else begin
                        // Bad mark length or a fifth element: swallow the rest of the letter.
                        state_next     = DISCARD;
                        space_run_next = 2'd1;
                    end
                end

                SPACE: begin
                    if (bus.bit_in) begin
                        if (space_run_reg == 2'd1) begin
                            state_next    = MARK;
                            mark_run_next = 3'd1;
                        end else begin
                            state_next     = DISCARD;
                            space_run_next = 2'd0;
                        end
                    end else if (space_run_reg == 2'd2) begin
                        if (match) begin
                            letter_next = match_code;
                            valid_next  = 1'b1;
                        end else begin
                            error_next = 1'b1;
                        end
                        state_next = IDLE;
                        clear_en   = 1'b1;
                    end else begin
                        space_run_next = space_run_reg + 2'd1;
                    end
                end

                DISCARD: begin
                    if (bus.bit_in) begin
                        space_run_next = 2'd0;
                    end else if (space_run_reg == 2'd2) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                        clear_en   = 1'b1;
                    end else begin
                        space_run_next = space_run_reg + 2'd1;
                    end
                end

                default: begin
                    state_next = IDLE;
                    clear_en   = 1'b1;
                end
            endcase
        end

        if (clear_en) begin
            mark_run_next  = 3'd0;
            space_run_next = 2'd0;
            count_next     = 3'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_ELEMS; gi++) begin : g_elem
            assign elem_next[gi] = clear_en ? 1'b0 :
                                   (store_en && count_reg == 3'(gi)) ? store_dash :
                                   elem_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            mark_run_reg  <= 3'd0;
            space_run_reg <= 2'd0;
            count_reg     <= 3'd0;
            elem_reg      <= 4'd0;
            letter_reg    <= 3'd0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mark_run_reg  <= mark_run_next;
            space_run_reg <= space_run_next;
            count_reg     <= count_next;
            elem_reg      <= elem_next;
            letter_reg    <= letter_next;
            valid_reg     <= valid_next;
            error_reg     <= error_next;
        end
    end

    assign bus.letter = letter_reg;
    assign bus.valid  = valid_reg;
    assign bus.error  = error_reg;
    assign bus.busy   = (state_reg != IDLE);

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 The `clock` port SHALL be an input, 1 bit wide, and is the system clock (CLOCK_50 domain); all state SHALL update on its rising edge.
REQ-003 The `reset` port SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-004 The `tick` port SHALL be an input, 1 bit wide: a one-cycle strobe marking each Morse bit period (0.5 s rate-divider terminal count).
REQ-005 The `bit_in` port SHALL be an input, 1 bit wide: the serial Morse bit (shifter Q), sampled only when tick=1.
REQ-006 The `letter` port SHALL be an output, 3 bits wide: the decoded character code (000=S, 001=T, 010=U, 011=V, 100=W, 101=X, 110=Y, 111=Z).
REQ-007 The `valid` port SHALL be an output, 1 bit wide: a one-cycle pulse when `letter` is newly decoded.
REQ-008 The `error` port SHALL be an output, 1 bit wide: a one-cycle pulse when a malformed or unknown letter is terminated.
REQ-009 The `busy` port SHALL be an output, 1 bit wide, and SHALL be 1 whenever the state is not IDLE.

Function
REQ-010 The block SHALL advance only on cycles with tick=1; on cycles with tick=0, all state, counters and the `letter` output SHALL hold, and `valid`/`error` SHALL be 0.
REQ-011 The line code SHALL be: dot = one 1; dash = three consecutive 1s; intra-letter gap = one 0; letter end = three consecutive 0s.
REQ-012 The FSM SHALL have the states IDLE, MARK, SPACE and DISCARD.
REQ-013 In IDLE, bit_in=0 SHALL keep the FSM in IDLE; bit_in=1 SHALL go to MARK with mark_run=1.
REQ-014 In MARK, bit_in=1 SHALL increment mark_run, saturating at 7.
REQ-015 In MARK, bit_in=0 SHALL classify the run: 1 is a dot (0), 3 is a dash (1), any other length goes to DISCARD with space_run=1.
REQ-016 In MARK, a valid element SHALL be stored at elem[count] and count incremented, then the FSM SHALL go to SPACE with space_run=1.
REQ-017 In MARK, if storing the element would make count exceed 4, the FSM SHALL go to DISCARD instead.
REQ-018 In SPACE, bit_in=1 with space_run=1 SHALL go to MARK with mark_run=1; bit_in=1 with space_run=2 SHALL go to DISCARD.
REQ-019 In SPACE, bit_in=0 SHALL increment space_run; when space_run reaches 3, the letter SHALL terminate and the FSM SHALL return to IDLE.
REQ-020 On termination, elem[0..count-1] (first-received first) SHALL be matched: S=..., T=-, U=..-, V=...-, W=.--, X=-..-, Y=-.--, Z=--..
REQ-021 On a match, `letter` SHALL be set to the code and `valid` SHALL pulse; on no match, `letter` SHALL hold and `error` SHALL pulse.
REQ-022 In DISCARD, 1s SHALL reset space_run to 0, and 0s SHALL increment it; on reaching 3, `error` SHALL pulse and the FSM SHALL go to IDLE.
REQ-023 Latency: `valid`/`error` SHALL be registered and asserted in the cycle immediately after the terminating tick, for exactly one cycle.
REQ-024 `valid` and `error` SHALL never be asserted together.
REQ-025 On each return to IDLE, elem, count, mark_run and space_run SHALL be cleared.
REQ-026 A stream that stays high indefinitely SHALL saturate mark_run at 7, SHALL NOT wrap, and SHALL later be reported as an error.

Reset
REQ-027 reset=1 at a rising clock edge SHALL force IDLE, clear all counters and elem, and set letter=000, valid=0, error=0 and busy=0.
REQ-028 Reset SHALL take priority over tick, including mid-letter; no `valid` or `error` SHALL be emitted for a letter interrupted by reset.
REQ-029 After reset deasserts, the block SHALL resume on the next tick.

Verification
REQ-030 Bench SHALL drive S: bits 1,0,1,0,1,0,0,0 on ticks -> one cycle after the 8th tick, valid=1 and letter=000; busy=0 afterwards.
REQ-031 Bench SHALL drive Y: bits 1,1,1,0,1,0,1,1,1,0,1,1,1,0,0,0 -> valid=1 and letter=110; a following Z stream -> letter=111.
REQ-032 Bench SHALL drive 1,1,0,0,0 -> error=1 once, valid=0, and letter keeps its previous value.
REQ-033 Bench SHALL drive five dots followed by 0,0,0 -> error=1 after the final 0; a subsequent T (1,1,1,0,0,0) -> valid=1 and letter=001.
REQ-034 Bench SHALL assert reset after 1,0,1 of an S, then release it and drive 1,1,1,0,0,0 -> no pulse during reset, then valid=1 and letter=001.
REQ-035 Bench SHALL space ticks 5 cycles apart with bit_in toggled between ticks -> decoding is identical to the dense-tick case, and valid/error are never asserted on non-tick cycles.
